// File: rtl/arith_pkg.sv
// Shared types for the registered four-function arithmetic unit.
package arith_pkg;
  typedef logic [1:0] op_t;

  localparam op_t OP_DEC_A = 2'b00;
  localparam op_t OP_ADD   = 2'b01;
  localparam op_t OP_SUB   = 2'b10;
  localparam op_t OP_NEG_B = 2'b11;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;
endpackage

// File: rtl/arith_unit_seq_if.sv
// Operand/result handshake bundle between source, arith unit and consumer.
interface arith_if
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             ovf_sticky;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg, ovf_sticky, acc
  );

  modport slave (
    input  in_valid, op, a, b, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg, ovf_sticky, acc
  );
endinterface

// File: rtl/arith_addsub_core.sv
// Combinational core: operand select, single adder, flags and optional saturation.
module arith_addsub_core
  import arith_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] acc,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);
  logic [WIDTH-1:0] ain, bin;
  logic             cin;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] low;
  logic             ovf;

  always_comb begin
    ain = acc_sel ? acc : a;
    bin = b;
    cin = 1'b0;
    unique case (op)
      OP_DEC_A: bin = '1;
      OP_ADD:   bin = b;
      OP_SUB:   begin bin = ~b; cin = 1'b1; end
      OP_NEG_B: begin ain = '0; bin = ~b; cin = 1'b1; end
      default:  bin = b;
    endcase

    full = {1'b0, ain} + {1'b0, bin} + (WIDTH+1)'(cin);
    // low[WIDTH-1] is the carry into the MSB
    low  = {1'b0, ain[WIDTH-2:0]} + {1'b0, bin[WIDTH-2:0]} + WIDTH'(cin);
    ovf  = low[WIDTH-1] ^ full[WIDTH];

    result = full[WIDTH-1:0];
    if (SATURATE && ovf)
      result = full[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};

    flags.carry = full[WIDTH];
    flags.ovf   = ovf;
    flags.zero  = (result == '0);
    flags.neg   = result[WIDTH-1];
  end
endmodule

// File: rtl/arith_unit_seq.sv
// Registered arithmetic unit: valid/ready handshake, one-entry result register,
// accumulator and sticky overflow around the combinational add/sub core.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input logic    clk,
  input logic    rst,
  arith_if.slave bus
);
  logic [WIDTH-1:0] core_res, result_q, acc_q;
  flags_t           core_flags, flags_q;
  logic             out_valid_q, sticky_q;
  logic             accept, deliver;

  arith_addsub_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
    .op      (bus.op),
    .a       (bus.a),
    .acc     (acc_q),
    .acc_sel (bus.acc_sel),
    .b       (bus.b),
    .result  (core_res),
    .flags   (core_flags)
  );

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign deliver      = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        result_q    <= core_res;
        flags_q     <= core_flags;
      end else if (deliver) begin
        out_valid_q <= 1'b0;
      end
      // clear wins over the update from an op accepted in the same cycle
      if (bus.acc_clr) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
      end else if (accept) begin
        acc_q    <= core_res;
        sticky_q <= sticky_q | core_flags.ovf;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.carry      = flags_q.carry;
  assign bus.ovf        = flags_q.ovf;
  assign bus.zero       = flags_q.zero;
  assign bus.neg        = flags_q.neg;
  assign bus.ovf_sticky = sticky_q;
  assign bus.acc        = acc_q;
endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq: plain and saturating instances driven in lockstep,
// checked by an integer-arithmetic reference model plus directed literals.
module tb_arith_unit_seq;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   armed = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  arith_if #(.WIDTH(8)) i0 ();
  arith_if #(.WIDTH(8)) i1 ();

  arith_unit_seq #(.WIDTH(8), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  arith_unit_seq #(.WIDTH(8), .SATURATE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1));

  // reference: {carry, ovf, zero, neg, result} from signed integer arithmetic
  function automatic logic [11:0] ref_op(input logic [1:0] o, input logic [7:0] av,
                                         input logic [7:0] bv, input bit sat);
    int sa, sb, t;
    logic c, v;
    logic [7:0] r;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    case (o)
      2'b00:   begin t = sa - 1;  c = (av != 8'd0); end
      2'b01:   begin t = sa + sb; c = ((int'(av) + int'(bv)) > 255); end
      2'b10:   begin t = sa - sb; c = (av >= bv); end
      default: begin t = -sb;     c = (bv == 8'd0); end
    endcase
    v = (t > 127) || (t < -128);
    r = t[7:0];
    if (sat && v) r = (t > 127) ? 8'h7F : 8'h80;
    return {c, v, (r == 8'd0), r[7], r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model state, index = SATURATE setting of the instance
  logic       m_ov [2];
  logic [11:0] m_fr [2];
  logic [7:0] m_acc [2];
  logic       m_st [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       acpt;
      logic [11:0] fr;
      if (rst) begin
        m_ov[k] = 1'b0; m_fr[k] = '0; m_acc[k] = '0; m_st[k] = 1'b0;
      end else begin
        acpt = i0.in_valid && (!m_ov[k] || i0.out_ready);
        fr   = ref_op(i0.op, i0.acc_sel ? m_acc[k] : i0.a, i0.b, k == 1);
        if (acpt) begin m_ov[k] = 1'b1; m_fr[k] = fr; end
        else if (m_ov[k] && i0.out_ready) m_ov[k] = 1'b0;
        if (i0.acc_clr) begin m_acc[k] = '0; m_st[k] = 1'b0; end
        else if (acpt) begin m_acc[k] = fr[7:0]; m_st[k] = m_st[k] | fr[10]; end
      end
    end
  end

  task automatic cmp(input int k, input logic [11:0] fr, input logic ov, input logic rdy,
                     input logic [7:0] ac, input logic st, input logic ordy);
    chk($sformatf("u%0d_out_valid", k), ov, m_ov[k]);
    chk($sformatf("u%0d_in_ready", k), rdy, !m_ov[k] || ordy);
    chk($sformatf("u%0d_acc", k), ac, m_acc[k]);
    chk($sformatf("u%0d_ovf_sticky", k), st, m_st[k]);
    if (m_ov[k]) chk($sformatf("u%0d_result_flags", k), fr, m_fr[k]);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, {i0.carry, i0.ovf, i0.zero, i0.neg, i0.result}, i0.out_valid, i0.in_ready,
          i0.acc, i0.ovf_sticky, i0.out_ready);
      cmp(1, {i1.carry, i1.ovf, i1.zero, i1.neg, i1.result}, i1.out_valid, i1.in_ready,
          i1.acc, i1.ovf_sticky, i1.out_ready);
    end
  end

  task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic sel, input logic clr);
    i0.in_valid = v; i0.op = o; i0.a = av; i0.b = bv; i0.acc_sel = sel; i0.acc_clr = clr;
    i1.in_valid = v; i1.op = o; i1.a = av; i1.b = bv; i1.acc_sel = sel; i1.acc_clr = clr;
  endtask

  task automatic set_ordy(input logic r);
    i0.out_ready = r;
    i1.out_ready = r;
  endtask

  // present one op for a single cycle; returns #1 after the accepting edge
  task automatic issue(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic sel, input logic clr);
    @(posedge clk); #1;
    drive(1'b1, o, av, bv, sel, clr);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    set_ordy(1'b1);

    // pin the reference model itself
    chk("model_dec_00", ref_op(2'b00, 8'h00, 8'h00, 1'b0), 12'h1FF);
    chk("model_dec_80_sat", ref_op(2'b00, 8'h80, 8'h00, 1'b1), 12'hD80);
    chk("model_add_7f_1", ref_op(2'b01, 8'h7F, 8'h01, 1'b0), 12'h580);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    chk("rst_out_valid", i0.out_valid, 1'b0);
    chk("rst_result", i0.result, 8'h00);
    chk("rst_flags", {i0.carry, i0.ovf, i0.zero, i0.neg}, 4'h0);
    chk("rst_acc", i0.acc, 8'h00);
    chk("rst_sticky", i0.ovf_sticky, 1'b0);

    issue(OP_DEC_A, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("dec0_valid", i0.out_valid, 1'b1);
    chk("dec0_result", i0.result, 8'hFF);
    chk("dec0_flags", {i0.carry, i0.ovf, i0.zero, i0.neg}, 4'b0001);

    issue(OP_DEC_A, 8'h80, 8'h00, 1'b0, 1'b0);
    chk("dec80_result", i0.result, 8'h7F);
    chk("dec80_cv", {i0.carry, i0.ovf}, 2'b11);
    chk("dec80_sat_result", i1.result, 8'h80);

    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("add7f_result", i0.result, 8'h80);
    chk("add7f_ovf_neg", {i0.ovf, i0.neg}, 2'b11);
    chk("add7f_sticky", i0.ovf_sticky, 1'b1);
    chk("add7f_sat_result", i1.result, 8'h7F);

    issue(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b0);
    chk("sub55_result", i0.result, 8'h00);
    chk("sub55_zero_carry", {i0.zero, i0.carry}, 2'b11);

    issue(OP_NEG_B, 8'h00, 8'h80, 1'b0, 1'b0);
    chk("neg80_result", i0.result, 8'h80);
    chk("neg80_ovf", i0.ovf, 1'b1);
    chk("neg80_sat_result", i1.result, 8'h7F);

    issue(OP_NEG_B, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("neg00_result", i0.result, 8'h00);
    chk("neg00_carry_zero", {i0.carry, i0.zero}, 2'b11);

    // backpressure
    @(posedge clk); #1;
    drive(1'b1, OP_ADD, 8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
    set_ordy(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", i0.result, 8'h30);
      chk("bp_in_ready", i0.in_ready, 1'b0);
      chk("bp_out_valid", i0.out_valid, 1'b1);
    end
    set_ordy(1'b1);
    #1 chk("bp_release_in_ready", i0.in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_second_result", i0.result, 8'h02);
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);

    // accumulator
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("acc_clr_acc", i0.acc, 8'h00);
    chk("acc_clr_sticky", i0.ovf_sticky, 1'b0);
    issue(OP_ADD, 8'h55, 8'h03, 1'b1, 1'b0);
    chk("acc_step1", i0.result, 8'd3);
    issue(OP_ADD, 8'h55, 8'h03, 1'b1, 1'b0);
    chk("acc_step2", i0.result, 8'd6);
    issue(OP_ADD, 8'h55, 8'h03, 1'b1, 1'b0);
    chk("acc_step3", i0.result, 8'd9);
    chk("acc_value", i0.acc, 8'd9);
    chk("acc_value_sat", i1.acc, 8'd9);
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("acc_sticky_set", i0.ovf_sticky, 1'b1);
    issue(OP_ADD, 8'h10, 8'h01, 1'b0, 1'b1);
    chk("clr_op_result", i0.result, 8'h11);
    chk("clr_op_valid", i0.out_valid, 1'b1);
    chk("clr_op_acc", i0.acc, 8'h00);
    chk("clr_op_sticky", i0.ovf_sticky, 1'b0);

    // reset with a pending undelivered result
    issue(OP_SUB, 8'h09, 8'h04, 1'b0, 1'b0);
    set_ordy(1'b0);
    chk("pend_result", i0.result, 8'h05);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_out_valid", i0.out_valid, 1'b0);
    chk("rst2_acc", i0.acc, 8'h00);
    chk("rst2_flags", {i0.carry, i0.ovf, i0.zero, i0.neg}, 4'h0);
    chk("rst2_result", i0.result, 8'h00);
    set_ordy(1'b1);

    repeat (3) @(posedge clk);
    #1 armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
